// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a 2-entry skid buffer.
// up_ready_o depends only on registered state, so no combinational path from dn_ready_i.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W         = 64,
  parameter logic [DATA_W-1:0]  FLUSH_VAL      = '0,
  parameter bit                 CLEAR_ON_FLUSH = 1'b1,
  parameter int unsigned        CNT_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, skid_q;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              up_fire, dn_fire;
  logic              load_main, main_from_skid, load_skid;

  // Handshake outputs decode the state register only.
  assign up_ready_o  = (state_q != FULL);
  assign dn_valid_o  = (state_q != EMPTY);
  assign dn_data_o   = main_q;
  assign occupancy_o = state_q;
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

  assign up_fire = up_valid_i & up_ready_o;
  assign dn_fire = dn_valid_o & dn_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; otherwise unassigned paths infer latches.
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (up_fire) begin
            state_d   = ONE;
            load_main = 1'b1;
          end
        end
        ONE: begin
          if (up_fire && dn_fire) begin
            load_main = 1'b1;
          end else if (up_fire) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (dn_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (dn_fire) begin
            state_d        = ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: payload registers are reset because FLUSH_VAL is visible on dn_data_o straight after reset.
    if (!rst_ni) begin
      main_q <= FLUSH_VAL;
      skid_q <= FLUSH_VAL;
    end else if (flush_i) begin
      if (CLEAR_ON_FLUSH) begin
        main_q <= FLUSH_VAL;
        skid_q <= FLUSH_VAL;
      end
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : up_data_i;
      if (load_skid) skid_q <= up_data_i;
    end
  end

  // Saturating event counters; flush does not clear them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (dn_valid_o && !dn_ready_i && (stall_q != CNT_MAX)) stall_q <= stall_q + CNT_W'(1);
      if (flush_i && (flush_q != CNT_MAX))                   flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vector table, corner-case sequences
// (counter saturation, async reset while full) and a random run against a scoreboard queue.
module tb_pipe_stage_skid;

  localparam int unsigned       DW = 16;
  localparam logic [DW-1:0]     FV = 16'hF1F0;

  logic          clk, rst_n;
  logic          flush, up_valid, dn_ready;
  logic [DW-1:0] up_data;
  logic          up_ready, dn_valid, up_ready_b, dn_valid_b;
  logic [DW-1:0] dn_data, dn_data_b;
  logic [1:0]    occ, occ_b;
  logic [3:0]    stall_cnt, flush_cnt, stall_cnt_b, flush_cnt_b;

  int n_vec = 0;
  int n_err = 0;

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_VAL(FV), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .up_valid_i(up_valid), .up_ready_o(up_ready), .up_data_i(up_data),
    .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data),
    .occupancy_o(occ), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .FLUSH_VAL(FV), .CLEAR_ON_FLUSH(1'b0), .CNT_W(4)) dut_hold (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .up_valid_i(up_valid), .up_ready_o(up_ready_b), .up_data_i(up_data),
    .dn_valid_o(dn_valid_b), .dn_ready_i(dn_ready), .dn_data_o(dn_data_b),
    .occupancy_o(occ_b), .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs applied this cycle, and outputs expected before this cycle's rising edge.
  typedef struct {
    logic          uv;
    logic [DW-1:0] ud;
    logic          rdy;
    logic          fl;
    logic          ur;
    logic          dv;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic [1:0]    occ;
    logic [3:0]    st;
    logic [3:0]    fc;
  } vec_t;

  vec_t vt[27];

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  initial begin
    logic [DW-1:0] sb[$];
    logic [DW-1:0] next_val;
    logic          hold, ur_snap, m_ready, m_fire;

    // Stream 0x1..0x8 with downstream always ready.
    for (int i = 0; i < 8; i++) begin
      vt[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b0,
                1'b1, (i != 0), (i == 0) ? FV : DW'(i), (i == 0) ? FV : DW'(i),
                (i == 0) ? 2'd0 : 2'd1, 4'd0, 4'd0};
    end
    vt[8]  = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h8, 16'h8, 2'd1, 4'd0, 4'd0};
    vt[9]  = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8, 16'h8, 2'd0, 4'd0, 4'd0};
    // Fill the skid buffer with A, B while C waits upstream, then drain.
    vt[10] = '{1'b1, 16'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'h8, 16'h8, 2'd0, 4'd0, 4'd0};
    vt[11] = '{1'b1, 16'hB, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA, 16'hA, 2'd1, 4'd0, 4'd0};
    vt[12] = '{1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA, 16'hA, 2'd2, 4'd1, 4'd0};
    vt[13] = '{1'b1, 16'hC, 1'b0, 1'b0, 1'b0, 1'b1, 16'hA, 16'hA, 2'd2, 4'd2, 4'd0};
    vt[14] = '{1'b1, 16'hC, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA, 16'hA, 2'd2, 4'd3, 4'd0};
    vt[15] = '{1'b1, 16'hC, 1'b1, 1'b0, 1'b1, 1'b1, 16'hB, 16'hB, 2'd1, 4'd3, 4'd0};
    vt[16] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hC, 16'hC, 2'd1, 4'd3, 4'd0};
    vt[17] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC, 16'hC, 2'd0, 4'd3, 4'd0};
    // Flush while FULL with D offered; then flush while EMPTY with D firing.
    vt[18] = '{1'b1, 16'hA, 1'b0, 1'b0, 1'b1, 1'b0, 16'hC, 16'hC, 2'd0, 4'd3, 4'd0};
    vt[19] = '{1'b1, 16'hB, 1'b0, 1'b0, 1'b1, 1'b1, 16'hA, 16'hA, 2'd1, 4'd3, 4'd0};
    vt[20] = '{1'b1, 16'hD, 1'b0, 1'b1, 1'b0, 1'b1, 16'hA, 16'hA, 2'd2, 4'd4, 4'd0};
    vt[21] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, FV,    16'hA, 2'd0, 4'd5, 4'd1};
    vt[22] = '{1'b1, 16'hD, 1'b1, 1'b1, 1'b1, 1'b0, FV,    16'hA, 2'd0, 4'd5, 4'd1};
    vt[23] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, FV,    16'hA, 2'd0, 4'd5, 4'd2};
    // Flush in ONE while both sides fire: the up payload 7 is dropped.
    vt[24] = '{1'b1, 16'h6, 1'b1, 1'b0, 1'b1, 1'b0, FV,    16'hA, 2'd0, 4'd5, 4'd2};
    vt[25] = '{1'b1, 16'h7, 1'b1, 1'b1, 1'b1, 1'b1, 16'h6, 16'h6, 2'd1, 4'd5, 4'd2};
    vt[26] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b0, FV,    16'h6, 2'd0, 4'd5, 4'd3};

    rst_n = 1'b0; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    #12;
    check("reset dn_valid", 32'(dn_valid), 32'd0);
    check("reset up_ready", 32'(up_ready), 32'd1);
    check("reset dn_data",  32'(dn_data),  32'(FV));
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      up_valid = vt[i].uv; up_data = vt[i].ud; dn_ready = vt[i].rdy; flush = vt[i].fl;
      #1;
      check($sformatf("v%0d up_ready", i),  32'(up_ready),  32'(vt[i].ur));
      check($sformatf("v%0d dn_valid", i),  32'(dn_valid),  32'(vt[i].dv));
      check($sformatf("v%0d dn_data", i),   32'(dn_data),   32'(vt[i].da));
      check($sformatf("v%0d hold_data", i), 32'(dn_data_b), 32'(vt[i].db));
      check($sformatf("v%0d occupancy", i), 32'(occ),       32'(vt[i].occ));
      check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vt[i].st));
      check($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(vt[i].fc));
    end

    // Stall counter saturates at 15 while one entry waits.
    @(negedge clk);
    up_valid = 1'b1; up_data = 16'h33; dn_ready = 1'b0; flush = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      up_valid = 1'b0;
      #1;
      check($sformatf("sat%0d dn_data", k),   32'(dn_data),   32'h33);
      check($sformatf("sat%0d stall_cnt", k), 32'(stall_cnt), 32'(min15(5 + k)));
    end

    // Flush counter saturates at 15.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      flush = 1'b1;
      #1;
      check($sformatf("fsat%0d flush_cnt", k), 32'(flush_cnt), 32'(min15(3 + k)));
    end
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fsat end flush_cnt", 32'(flush_cnt), 32'd15);
    check("fsat end dn_valid",  32'(dn_valid),  32'd0);

    // Asynchronous reset between edges while FULL.
    @(negedge clk); up_valid = 1'b1; up_data = 16'hA;
    @(negedge clk); up_data = 16'hB;
    @(negedge clk); up_valid = 1'b0;
    #1;
    check("arst pre occupancy", 32'(occ), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst dn_valid",  32'(dn_valid),  32'd0);
    check("arst up_ready",  32'(up_ready),  32'd1);
    check("arst occupancy", 32'(occ),       32'd0);
    check("arst dn_data",   32'(dn_data),   32'(FV));
    check("arst hold_data", 32'(dn_data_b), 32'(FV));
    check("arst stall_cnt", 32'(stall_cnt), 32'd0);
    check("arst flush_cnt", 32'(flush_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; up_valid = 1'b1; up_data = 16'h5; dn_ready = 1'b1;
    #1;
    check("post-rst dn_valid0", 32'(dn_valid), 32'd0);
    @(negedge clk);
    up_valid = 1'b0;
    #1;
    check("post-rst dn_valid1", 32'(dn_valid), 32'd1);
    check("post-rst dn_data",   32'(dn_data),  32'h5);
    @(negedge clk);
    #1;
    check("post-rst drained", 32'(dn_valid), 32'd0);

    // Random traffic against a scoreboard queue.
    next_val = 16'h0100;
    hold = 1'b0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      if (!hold) begin
        up_valid = ($urandom_range(0, 3) != 0);
        up_data  = next_val;
      end
      dn_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      #1;
      ur_snap  = up_ready;
      dn_ready = ~dn_ready;
      #1;
      check($sformatf("r%0d ready isolation", cyc), 32'(up_ready), 32'(ur_snap));
      dn_ready = ~dn_ready;
      #1;
      m_ready = (sb.size() < 2);
      check($sformatf("r%0d up_ready", cyc),  32'(up_ready), 32'(m_ready));
      check($sformatf("r%0d dn_valid", cyc),  32'(dn_valid), 32'(sb.size() != 0));
      check($sformatf("r%0d occupancy", cyc), 32'(occ),      32'(sb.size()));
      if (sb.size() != 0 && dn_ready) begin
        check($sformatf("r%0d dn_data", cyc), 32'(dn_data), 32'(sb[0]));
        void'(sb.pop_front());
      end
      m_fire = up_valid && m_ready;
      if (flush) sb.delete();
      else if (m_fire) sb.push_back(up_data);
      if (m_fire) next_val = next_val + 16'd1;
      hold = up_valid && !m_ready;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
